// File: rtl/deser8.sv
// Serial-to-parallel converter: collects 8 accepted bits into a byte and
// hands it to a consumer over a valid/ready holding register with overrun flag.
module deser8 #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       any_one,
    output logic       overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_count;
    logic [7:0] next_shift;
    logic       completion;

    // The byte as it will look once this edge's bit is shifted in, so a
    // completing edge can load the holding register directly.
    always_comb begin
        next_shift = MSB_FIRST ? {shift_reg[6:0], bit_in} : {bit_in, shift_reg[7:1]};
        completion = bit_valid && (bit_count == 3'd7);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            shift_reg <= 8'h00;
            bit_count <= 3'd0;
            out       <= 8'h00;
            any_one   <= 1'b0;
            overrun   <= 1'b0;
        end else if (clear) begin
            state     <= EMPTY;
            shift_reg <= 8'h00;
            bit_count <= 3'd0;
            out       <= 8'h00;
            any_one   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bit_valid) begin
                shift_reg <= next_shift;
                bit_count <= bit_count + 3'd1;
            end
            // A completion while the consumer is also taking the held byte
            // reloads in place, so there is no empty bubble between bytes.
            case (state)
                EMPTY: begin
                    if (completion) begin
                        out     <= next_shift;
                        any_one <= |next_shift;
                        state   <= HELD;
                    end
                end
                HELD: begin
                    if (completion) begin
                        if (out_ready) begin
                            out     <= next_shift;
                            any_one <= |next_shift;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state == HELD);

endmodule

// File: tb/tb_deser8.sv
// Scoreboard bench for deser8: directed bytes push expected results, a forked
// monitor pops and compares each newly presented byte.
module tb_deser8;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       bit_in;
    logic       bit_valid;
    logic       out_ready;
    logic [7:0] out0;
    logic       out_valid0;
    logic       any_one0;
    logic       overrun0;
    logic [7:0] out1;
    logic       out_valid1;
    logic       any_one1;
    logic       overrun1;

    typedef struct packed {
        logic [7:0] data;
        logic       any;
    } exp_t;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;

    deser8 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in),
        .bit_valid(bit_valid), .out(out0), .out_valid(out_valid0),
        .out_ready(out_ready), .any_one(any_one0), .overrun(overrun0)
    );

    deser8 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in),
        .bit_valid(bit_valid), .out(out1), .out_valid(out_valid1),
        .out_ready(out_ready), .any_one(any_one1), .overrun(overrun1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [7:0] actual,
                                input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    // Sends b[0] first; with gap>0 idle cycles separate the bits.
    task automatic apply_stimulus(input logic [7:0] b, input logic ready_last,
                                  input int gap);
        for (int i = 0; i < 8; i++) begin
            bit_in    = b[i];
            bit_valid = 1'b1;
            out_ready = (i == 7) ? ready_last : 1'b0;
            @(posedge clk);
            #1;
            bit_valid = 1'b0;
            out_ready = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n, input logic ready);
        out_ready = ready;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
    endtask

    // A byte counts as newly presented when out_valid rises or the previous
    // byte was taken on the edge that loaded it.
    task automatic monitor_loop();
        logic seen;
        logic taken;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(posedge clk);
            taken = out_valid0 && out_ready && !clear && !reset;
            @(negedge clk);
            if (!out_valid0 || taken) seen = 1'b0;
            if (out_valid0 && !seen) begin
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_byte: got %02h, expected none", out0);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_out", out0, e.data);
                    check_output("sb_any_one", {7'd0, any_one0}, {7'd0, e.any});
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        clear      = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        out_ready  = 1'b0;
        fork
            monitor_loop();
        join_none
        #12;
        check_output("reset_out", out0, 8'h00);
        check_output("reset_out_valid", {7'd0, out_valid0}, 8'h00);
        check_output("reset_any_one", {7'd0, any_one0}, 8'h00);
        check_output("reset_overrun", {7'd0, overrun0}, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, 1'b0);

        // Bits 1,0,1,0,0,0,0,1: 85 LSB-first, A1 MSB-first
        exp_q.push_back('{data: 8'h85, any: 1'b1});
        apply_stimulus(8'h85, 1'b0, 0);
        check_output("first_out_valid", {7'd0, out_valid0}, 8'h01);
        check_output("first_overrun", {7'd0, overrun0}, 8'h00);
        check_output("msb_first_out", out1, 8'hA1);
        check_output("msb_first_any_one", {7'd0, any_one1}, 8'h01);

        // Back-to-back handoff with no bubble, then drain
        exp_q.push_back('{data: 8'h3C, any: 1'b1});
        apply_stimulus(8'h3C, 1'b1, 0);
        check_output("b2b_out_valid", {7'd0, out_valid0}, 8'h01);
        check_output("b2b_out", out0, 8'h3C);
        idle(1, 1'b1);
        check_output("drain_out_valid", {7'd0, out_valid0}, 8'h00);
        check_output("drain_out_kept", out0, 8'h3C);
        idle(1, 1'b1);

        // All-zero byte with idle gaps between bits
        exp_q.push_back('{data: 8'h00, any: 1'b0});
        apply_stimulus(8'h00, 1'b0, 2);
        check_output("zero_out_valid", {7'd0, out_valid0}, 8'h01);
        check_output("zero_any_one", {7'd0, any_one0}, 8'h00);
        idle(1, 1'b1);

        // Overrun: FF completes while 85 is still held
        exp_q.push_back('{data: 8'h85, any: 1'b1});
        apply_stimulus(8'h85, 1'b0, 0);
        apply_stimulus(8'hFF, 1'b0, 0);
        check_output("overrun_out_kept", out0, 8'h85);
        check_output("overrun_set", {7'd0, overrun0}, 8'h01);
        idle(2, 1'b0);
        check_output("overrun_sticky", {7'd0, overrun0}, 8'h01);

        // Partial bits, then clear with a bit presented on the same edge
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        clear = 1'b1; bit_in = 1'b1; bit_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
        check_output("clear_out_valid", {7'd0, out_valid0}, 8'h00);
        check_output("clear_overrun", {7'd0, overrun0}, 8'h00);
        check_output("clear_out", out0, 8'h00);
        check_output("clear_any_one", {7'd0, any_one0}, 8'h00);
        exp_q.push_back('{data: 8'h01, any: 1'b1});
        apply_stimulus(8'h01, 1'b0, 0);
        idle(1, 1'b0);

        // Asynchronous reset mid-byte while 01 is held
        for (int i = 0; i < 5; i++) begin
            bit_in = 1'b1; bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_output("async_reset_out", out0, 8'h00);
        check_output("async_reset_out_valid", {7'd0, out_valid0}, 8'h00);
        check_output("async_reset_any_one", {7'd0, any_one0}, 8'h00);
        #1 reset = 1'b0;
        idle(1, 1'b0);
        exp_q.push_back('{data: 8'h01, any: 1'b1});
        apply_stimulus(8'h01, 1'b0, 0);
        check_output("post_reset_out", out0, 8'h01);
        idle(3, 1'b0);

        check_output("scoreboard_drained", exp_q.size()[7:0], 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/deser8.md
DESER8 -- requirements
Module: deser8

Interface
REQ-001 Parameter MSB_FIRST, default 0: 0 = first received bit lands in out[0]; 1 = first received bit lands in out[7].
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 clear  input  1  synchronous restart of the collection, output and flag state.
REQ-005 bit_in  input  1  serial data bit.
REQ-006 bit_valid  input  1  bit_in is accepted on any rising clk edge where this is high; there is no backpressure on the serial side.
REQ-007 out  output  8  assembled byte; stable while out_valid=1.
REQ-008 out_valid  output  1  out holds an unconsumed byte.
REQ-009 out_ready  input  1  consumer accepts out on any edge where out_valid=1 and out_ready=1.
REQ-010 any_one  output  1  registered OR-reduction of out; updates in the same cycle that out loads.
REQ-011 overrun  output  1  sticky; a completed byte was discarded.

Function
REQ-012 Collection path: 8-bit shift register and 3-bit bit counter, count 0..7.
REQ-013 Output path: separate 8-bit holding register driving out, so collection of the next byte continues while a byte is held.
REQ-014 Accepted bit with MSB_FIRST=0: shift right, bit_in enters bit 7; after 8 bits, the first bit is in bit 0.
REQ-015 Accepted bit with MSB_FIRST=1: shift left, bit_in enters bit 0; after 8 bits, the first bit is in bit 7.
REQ-016 Counter increments on each accepted bit and wraps 7->0 on the eighth bit ("byte completion").
REQ-017 Output FSM states: EMPTY (out_valid=0) and HELD (out_valid=1).
REQ-018 EMPTY + completion: load holding register with the assembled byte (including the bit accepted this edge), go to HELD.
REQ-019 Latency: out, any_one and out_valid are valid immediately after the edge that accepts the 8th bit (1 clock).
REQ-020 HELD + out_ready=1 + no completion: go to EMPTY; out keeps its last value.
REQ-021 HELD + out_ready=1 + completion on the same edge: load the new byte and stay in HELD, with no bubble cycle.
REQ-022 HELD + out_ready=0 + completion: discard the new byte, leave out unchanged, set overrun=1; counter still wraps to 0.
REQ-023 overrun clears only on reset or clear.
REQ-024 any_one = 1 iff the loaded byte is non-zero; it is recomputed only at load time.
REQ-025 clear=1 on an edge: counter=0, shift register=0, holding register=0, any_one=0, out_valid=0, overrun=0.
REQ-026 clear overrides bit_valid and out_ready on the same edge; the bit presented on that edge is dropped.
REQ-027 out_ready while EMPTY is ignored.
REQ-028 bit_valid=0 leaves the counter and shift register unchanged for any number of cycles; partial bytes persist.

Reset
REQ-029 reset=1 forces, asynchronously, without waiting for clk: out=8'h00, out_valid=0, any_one=0, overrun=0, counter=0, shift register=0, FSM=EMPTY.
REQ-030 reset asserted mid-byte discards the partial byte; after release the next accepted bit is bit 0 of a new byte.
REQ-031 No bit is accepted on an edge where reset=1.

Verification
REQ-032 MSB_FIRST=0: send bits 1,0,1,0,0,0,0,1 on consecutive cycles with out_ready=0 -> after the 8th edge, out=8'h85, out_valid=1, any_one=1, overrun=0.
REQ-033 MSB_FIRST=1: same bit sequence -> out=8'hA1.
REQ-034 Eight 0 bits -> out=8'h00, out_valid=1, any_one=0.
REQ-035 With 8'h85 held and out_ready=1 on the same edge as the 8th bit of 8'h3C -> out=8'h3C and out_valid stays 1 with no gap; then out_ready=1 for one cycle -> out_valid=0.
REQ-036 With 8'h85 held and out_ready=0, complete 8'hFF -> out stays 8'h85 and overrun=1; assert clear -> out_valid=0, overrun=0, out=8'h00.
REQ-037 Send 5 bits, pulse reset asynchronously between clk edges -> outputs zero immediately; then 8 bits of 8'h01 -> out=8'h01.
